// File: rtl/mp_tpcs_usb4_pkg.sv
// rtl/mp_tpcs_usb4_pkg.sv - shared rate codes, FSM states and default widths
package mp_tpcs_usb4_pkg;

   localparam logic [1:0] RATE_G2 = 2'b00;
   localparam logic [1:0] RATE_G3 = 2'b01;
   localparam logic [1:0] RATE_G4 = 2'b10;

   localparam int DEF_PMA_W        = 32;
   localparam int DEF_PIPE_W       = 40;
   localparam int DEF_G4_W         = 28;
   localparam int DEF_MIN_IDLE_CYC = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/mp_tpcs_usb4_g4_acc.sv
// rtl/mp_tpcs_usb4_g4_acc.sv - Gen4 gearbox: packs G4_W-bit symbols into PMA_W-bit words
module mp_tpcs_usb4_g4_acc
   import mp_tpcs_usb4_pkg::*;
#(
   parameter  int PMA_W = DEF_PMA_W,
   parameter  int G4_W  = DEF_G4_W,
   localparam int CW    = $clog2(2 * PMA_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [G4_W-1:0]  sym,
   input  logic             flush,
   input  logic             drain,
   output logic [PMA_W-1:0] word,
   output logic             word_vld,
   output logic [CW-1:0]    cnt
);

   localparam int          AW    = 2 * PMA_W;
   localparam logic [CW:0] G4_N  = (CW + 1)'(G4_W);
   localparam logic [CW:0] PMA_N = (CW + 1)'(PMA_W);

   logic [AW-1:0]    acc;
   logic [AW-1:0]    acc_new;
   logic [CW:0]      n;
   logic [CW:0]      n_rem;
   logic [PMA_W-1:0] keep_mask;

   always_comb begin
      acc_new   = acc | ({{(AW - G4_W){1'b0}}, sym} << cnt);
      n         = {1'b0, cnt} + G4_N;
      n_rem     = n - PMA_N;
      // the drain word only carries the cnt bits still pending
      keep_mask = ~({PMA_W{1'b1}} << cnt);
      word      = drain ? (acc[PMA_W-1:0] & keep_mask) : acc_new[PMA_W-1:0];
      word_vld  = drain | (push & (n >= PMA_N));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (flush | drain) begin
         acc <= '0;
         cnt <= '0;
      end else if (push) begin
         if (n >= PMA_N) begin
            acc <= acc_new >> PMA_W;
            cnt <= n_rem[CW-1:0];
         end else begin
            acc <= acc_new;
            cnt <= n[CW-1:0];
         end
      end
   end

endmodule

// File: rtl/mp_tpcs_usb4_tx_gbox.sv
// rtl/mp_tpcs_usb4_tx_gbox.sv - USB4 PIPE-to-PMA Tx path with Gen4 gearbox and idle sequencing
module mp_tpcs_usb4_tx_gbox
   import mp_tpcs_usb4_pkg::*;
#(
   parameter int PMA_W        = DEF_PMA_W,
   parameter int PIPE_W       = DEF_PIPE_W,
   parameter int G4_W         = DEF_G4_W,
   parameter int MIN_IDLE_CYC = DEF_MIN_IDLE_CYC
) (
   input  logic              tx_clk,
   input  logic              tx_rst_n,
   input  logic [1:0]        pipe_rate,
   input  logic [PIPE_W-1:0] pipe_tx_data,
   input  logic [3:0]        pipe_tx_elec_idle,
   input  logic              pipe_tx_data_valid,
   input  logic              override_en,
   output logic [PMA_W-1:0]  pma_tx_td,
   output logic              pma_tx_td_valid,
   output logic              pma_tx_elec_idle,
   output logic              idle_viol
);

   localparam int         CW        = $clog2(2 * PMA_W);
   localparam logic [7:0] HOLD_INIT = 8'(MIN_IDLE_CYC - 1);

   tx_state_e        state;
   logic [1:0]       rate_q;
   logic [7:0]       hold;
   logic [PMA_W-1:0] lane_word;
   logic [PMA_W-1:0] word;
   logic [PMA_W-1:0] g4_word;
   logic             g4_vld;
   logic [CW-1:0]    cnt;
   logic             req_idle;
   logic             rate_chg;
   logic             g4_mode;
   logic             take;
   logic             drain;
   logic             push;
   logic             flush;
   logic             unused_ok;

   // 8b of every 10b PIPE group carry payload at Gen2/Gen3
   for (genvar k = 0; k < PMA_W / 8; k++) begin : g_ext
      assign lane_word[8*k +: 8] = pipe_tx_data[10*k +: 8];
   end

   assign word      = override_en ? pipe_tx_data[PMA_W-1:0] : lane_word;
   assign req_idle  = ~pipe_tx_data_valid | pipe_tx_elec_idle[0];
   assign rate_chg  = (pipe_rate != rate_q);
   assign g4_mode   = (pipe_rate == RATE_G4) & ~override_en;
   assign take      = ~req_idle & ~rate_chg &
                      ((state == ACTIVE) | ((state == IDLE) & (hold == '0)));
   assign drain     = (state == ACTIVE) & (req_idle | rate_chg) & (cnt != '0);
   assign push      = take & g4_mode;
   assign flush     = (rate_chg | override_en) & ~drain;
   assign unused_ok = ^{pipe_tx_elec_idle[3:1], pipe_tx_data[PIPE_W-1:PMA_W]};

   mp_tpcs_usb4_g4_acc #(
      .PMA_W (PMA_W),
      .G4_W  (G4_W)
   ) u_g4_acc (
      .clk      (tx_clk),
      .rst_n    (tx_rst_n),
      .push     (push),
      .sym      (pipe_tx_data[G4_W-1:0]),
      .flush    (flush),
      .drain    (drain),
      .word     (g4_word),
      .word_vld (g4_vld),
      .cnt      (cnt)
   );

   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state            <= IDLE;
         rate_q           <= RATE_G2;
         hold             <= '0;
         pma_tx_td        <= '0;
         pma_tx_td_valid  <= 1'b0;
         pma_tx_elec_idle <= 1'b1;
         idle_viol        <= 1'b0;
      end else begin
         rate_q <= pipe_rate;
         if (take) begin
            state            <= ACTIVE;
            pma_tx_elec_idle <= 1'b0;
            if (g4_mode) begin
               pma_tx_td_valid <= g4_vld;
               if (g4_vld) pma_tx_td <= g4_word;
            end else begin
               pma_tx_td       <= word;
               pma_tx_td_valid <= 1'b1;
            end
         end else if (drain) begin
            state            <= DRAIN;
            pma_tx_td        <= g4_word;
            pma_tx_td_valid  <= 1'b1;
            pma_tx_elec_idle <= 1'b0;
         end else if (state == IDLE) begin
            pma_tx_td        <= '0;
            pma_tx_td_valid  <= 1'b0;
            pma_tx_elec_idle <= 1'b1;
            if (hold != '0) begin
               hold <= hold - 8'd1;
               if (!req_idle) idle_viol <= 1'b1;
            end
         end else begin
            // leaving ACTIVE with nothing buffered, or the DRAIN word has gone out
            state            <= IDLE;
            pma_tx_td        <= '0;
            pma_tx_td_valid  <= 1'b0;
            pma_tx_elec_idle <= 1'b1;
            hold             <= HOLD_INIT;
         end
      end
   end

endmodule

// File: tb/tb_mp_tpcs_usb4_tx_gbox.sv
// tb/tb_mp_tpcs_usb4_tx_gbox.sv - self-checking bench for mp_tpcs_usb4_tx_gbox
module tb_mp_tpcs_usb4_tx_gbox;

   localparam int PMA_W    = 32;
   localparam int PIPE_W   = 40;
   localparam int G4_W     = 28;
   localparam int MIN_IDLE = 8;

   logic              tx_clk = 1'b0;
   logic              tx_rst_n = 1'b0;
   logic [1:0]        pipe_rate = 2'b00;
   logic [PIPE_W-1:0] pipe_tx_data = '0;
   logic [3:0]        pipe_tx_elec_idle = 4'h0;
   logic              pipe_tx_data_valid = 1'b0;
   logic              override_en = 1'b0;
   logic [PMA_W-1:0]  pma_tx_td;
   logic              pma_tx_td_valid;
   logic              pma_tx_elec_idle;
   logic              idle_viol;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // expected outputs and abstract model state: phase 0=idle 1=sending 2=flushing residue
   logic [PMA_W-1:0] e_td;
   logic             e_vld, e_eidle, e_viol;
   int               m_phase;
   int               m_idle_seen;
   logic [1:0]       m_rate;
   bit               m_bits[$];

   mp_tpcs_usb4_tx_gbox #(
      .PMA_W        (PMA_W),
      .PIPE_W       (PIPE_W),
      .G4_W         (G4_W),
      .MIN_IDLE_CYC (MIN_IDLE)
   ) dut (
      .tx_clk             (tx_clk),
      .tx_rst_n           (tx_rst_n),
      .pipe_rate          (pipe_rate),
      .pipe_tx_data       (pipe_tx_data),
      .pipe_tx_elec_idle  (pipe_tx_elec_idle),
      .pipe_tx_data_valid (pipe_tx_data_valid),
      .override_en        (override_en),
      .pma_tx_td          (pma_tx_td),
      .pma_tx_td_valid    (pma_tx_td_valid),
      .pma_tx_elec_idle   (pma_tx_elec_idle),
      .idle_viol          (idle_viol)
   );

   always #5 tx_clk = ~tx_clk;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PMA_W-1:0] ref_word(logic [PIPE_W-1:0] d, logic ovr);
      logic [PMA_W-1:0] w;
      w = '0;
      if (ovr) return d[PMA_W-1:0];
      for (int k = 0; k < PMA_W / 8; k++)
         for (int b = 0; b < 8; b++)
            w[8*k+b] = d[10*k+b];
      return w;
   endfunction

   task automatic model_reset();
      e_td        = '0;
      e_vld       = 1'b0;
      e_eidle     = 1'b1;
      e_viol      = 1'b0;
      m_phase     = 0;
      m_idle_seen = MIN_IDLE;
      m_rate      = 2'b00;
      m_bits.delete();
   endtask

   task automatic model_take();
      e_eidle = 1'b0;
      if (pipe_rate == 2'b10 && !override_en) begin
         for (int i = 0; i < G4_W; i++) m_bits.push_back(pipe_tx_data[i]);
         e_vld = 1'b0;
         if (m_bits.size() >= PMA_W) begin
            for (int i = 0; i < PMA_W; i++) e_td[i] = m_bits.pop_front();
            e_vld = 1'b1;
         end
      end else begin
         e_td  = ref_word(pipe_tx_data, override_en);
         e_vld = 1'b1;
      end
   endtask

   task automatic go_idle();
      e_td        = '0;
      e_vld       = 1'b0;
      e_eidle     = 1'b1;
      m_phase     = 0;
      m_idle_seen = 0;
   endtask

   task automatic model_step();
      logic ri, rc;
      ri     = !pipe_tx_data_valid || pipe_tx_elec_idle[0];
      rc     = (pipe_rate != m_rate);
      m_rate = pipe_rate;
      case (m_phase)
         0: begin
            e_td    = '0;
            e_vld   = 1'b0;
            e_eidle = 1'b1;
            if (m_idle_seen < MIN_IDLE) m_idle_seen++;
            if (!ri && m_idle_seen < MIN_IDLE) e_viol = 1'b1;
            else if (!ri && !rc) begin
               m_phase = 1;
               model_take();
            end
         end
         1: begin
            if (ri || rc) begin
               if (m_bits.size() > 0) begin
                  e_td = '0;
                  for (int i = 0; i < m_bits.size(); i++) e_td[i] = m_bits[i];
                  e_vld   = 1'b1;
                  e_eidle = 1'b0;
                  m_bits.delete();
                  m_phase = 2;
               end else go_idle();
            end else model_take();
         end
         default: go_idle();
      endcase
      if (rc || override_en) m_bits.delete();
   endtask

   always @(negedge tx_clk) begin
      if (chk_en) begin
         check("td", pma_tx_td, e_td);
         check("td_valid", pma_tx_td_valid, e_vld);
         check("elec_idle", pma_tx_elec_idle, e_eidle);
         check("idle_viol", idle_viol, e_viol);
      end
   end

   task automatic drive(logic v, logic [1:0] r, logic [PIPE_W-1:0] d,
                        logic ovr = 1'b0, logic ei = 1'b0);
      pipe_tx_data_valid = v;
      pipe_rate          = r;
      pipe_tx_data       = d;
      override_en        = ovr;
      pipe_tx_elec_idle  = {3'b000, ei};
      @(posedge tx_clk);
      model_step();
      @(negedge tx_clk);
   endtask

   task automatic idle(int n, logic [1:0] r);
      repeat (n) drive(1'b0, r, '0);
   endtask

   initial begin
      int cnt_eidle;
      int pulses;
      model_reset();
      chk_en = 1'b1;
      repeat (2) @(negedge tx_clk);
      check("rst_td", pma_tx_td, 32'h0);
      check("rst_vld", pma_tx_td_valid, 1'b0);
      check("rst_eidle", pma_tx_elec_idle, 1'b1);
      check("rst_viol", idle_viol, 1'b0);
      tx_rst_n = 1'b1;

      // Gen3 extraction
      drive(1'b0, 2'b01, '0);
      drive(1'b1, 2'b01, 40'h3_FF00_AA55);
      check("g3_td", pma_tx_td, 32'h0FF0_2A55);
      check("g3_vld", pma_tx_td_valid, 1'b1);
      check("g3_eidle", pma_tx_elec_idle, 1'b0);
      drive(1'b1, 2'b01, 40'h12_3456_789A);
      drive(1'b1, 2'b01, 40'hFF_FFFF_FFFF);
      drive(1'b0, 2'b01, '0);

      // data during minimum idle hold is dropped
      idle(3, 2'b01);
      drive(1'b1, 2'b01, 40'h55_5555_5555);
      check("viol_set", idle_viol, 1'b1);
      check("viol_eidle", pma_tx_elec_idle, 1'b1);
      repeat (3) drive(1'b1, 2'b01, 40'h55_5555_5555);
      drive(1'b1, 2'b01, 40'h55_5555_5555);
      check("after_hold_vld", pma_tx_td_valid, 1'b1);
      check("after_hold_td", pma_tx_td, 32'h5555_5555);
      drive(1'b1, 2'b01, 40'h55_5555_5555, 1'b0, 1'b1);

      // rate change Gen3 -> Gen4 while active, then 8 Gen4 symbols
      idle(8, 2'b01);
      drive(1'b1, 2'b01, 40'h01_0203_0405);
      drive(1'b1, 2'b01, 40'h06_0708_090A);
      drive(1'b1, 2'b10, 40'h1);
      cnt_eidle = (pma_tx_elec_idle === 1'b1) ? 1 : 0;
      for (int i = 0; i < MIN_IDLE - 1; i++) begin
         drive(1'b0, 2'b10, '0);
         if (pma_tx_elec_idle === 1'b1) cnt_eidle++;
      end
      check("rc_idle_cycles", cnt_eidle, MIN_IDLE);
      pulses = 0;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 2'b10, 40'(i));
         if (pma_tx_td_valid === 1'b1) pulses++;
         if (i == 2) check("g4_first_word", pma_tx_td, 32'h2000_0001);
      end
      check("g4_pulses", pulses, 7);
      drive(1'b0, 2'b10, '0);
      check("g4_no_drain_eidle", pma_tx_elec_idle, 1'b1);

      // Gen4 residue drained after 3 symbols
      idle(8, 2'b10);
      drive(1'b1, 2'b10, 40'h000ABCDEF1);
      drive(1'b1, 2'b10, 40'h0002345678);
      check("dr_w1", pma_tx_td, 32'h8ABC_DEF1);
      drive(1'b1, 2'b10, 40'h0009876543);
      check("dr_w2", pma_tx_td, 32'h4323_4567);
      drive(1'b0, 2'b10, '0);
      check("dr_word", pma_tx_td, 32'h0009_8765);
      check("dr_vld", pma_tx_td_valid, 1'b1);
      drive(1'b0, 2'b10, '0);
      check("dr_then_idle", pma_tx_elec_idle, 1'b1);

      // override bypass and asynchronous reset mid-stream
      idle(8, 2'b10);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b10, 40'hAB_1234_5678, 1'b1);
         check("ovr_td", pma_tx_td, 32'h1234_5678);
         check("ovr_vld", pma_tx_td_valid, 1'b1);
      end
      pipe_tx_data_valid = 1'b1;
      #2 tx_rst_n = 1'b0;
      #1;
      check("arst_td", pma_tx_td, 32'h0);
      check("arst_eidle", pma_tx_elec_idle, 1'b1);
      check("arst_vld", pma_tx_td_valid, 1'b0);
      model_reset();
      @(negedge tx_clk);
      tx_rst_n = 1'b1;

      // override toggling around a partially filled gearbox
      drive(1'b1, 2'b10, 40'hAB_1234_5678, 1'b1);
      drive(1'b1, 2'b10, 40'hAB_1234_5678, 1'b1);
      drive(1'b1, 2'b10, 40'h000FEDCBA9, 1'b0);
      drive(1'b1, 2'b10, 40'hCD_8765_4321, 1'b1);
      drive(1'b1, 2'b10, 40'h0001111111, 1'b0);
      drive(1'b1, 2'b10, 40'h0002222222, 1'b0);
      drive(1'b0, 2'b10, '0);
      idle(3, 2'b10);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
